noc_xbar_router: RTL and testbench
==================================

// Module: noc_xbar_router
// PURPOSE
//  Parametrised NUM_PORTS-in / NUM_PORTS-out NoC router for the PE mesh.
//  Each input port has a FIFO of FIFO_DEPTH flits. Each flit carries its own output-port index (dest).
//  Each output port has a registered stage and a round-robin arbiter across inputs.
//  Flits with an out-of-range dest are dropped and counted.
// PARAMETERS
//  NUM_PORTS   5   ports per router (default N,S,E,W,Local)
//  DATA_WIDTH  32  flit payload width
//  DEST_W      3   dest/source index width; must satisfy 2**DEST_W >= NUM_PORTS
//  FIFO_DEPTH  4   per-input FIFO depth; power of 2, >= 2
//  CNT_W       16  drop counter width
// PORTS
//  clk         in   1                    clock, rising edge
//  rst         in   1                    asynchronous, active-high reset
//  in_data     in   NUM_PORTS*DATA_WIDTH input flit payloads; port i = slice i
//  in_dest     in   NUM_PORTS*DEST_W     destination output-port index per input
//  in_valid    in   NUM_PORTS            input flit valid
//  in_ready    out  NUM_PORTS            input FIFO can accept
//  out_data    out  NUM_PORTS*DATA_WIDTH output flit payloads
//  out_src     out  NUM_PORTS*DEST_W     index of the input port the flit arrived on
//  out_valid   out  NUM_PORTS            output flit valid
//  out_ready   in   NUM_PORTS            downstream accepts
//  drop_count  out  CNT_W                saturating count of dropped flits
// BEHAVIOUR
//  Reset (async, active-high):
//   - all FIFOs empty; in_ready=all-1 (after reset deasserts)
//   - out_valid=0, out_data=0, out_src=0, drop_count=0
//   - all RR pointers = NUM_PORTS-1, so port 0 has first priority
//   - reset mid-operation discards all buffered and in-flight flits
//  Input handshake:
//   - push on port i when in_valid[i] & in_ready[i] at a rising edge
//   - in_ready[i] = !full[i]; based on the registered count only, not on a same-cycle pop
//   - in_valid high with in_ready low: no state change
//  Routing: head flit of FIFO i with dest d requests output d only if d < NUM_PORTS.
//  Drop:
//   - a head with d >= NUM_PORTS is popped on the next edge and never reaches an output
//   - drop_count increments by 1 per dropped flit and saturates at 2**CNT_W-1
//   - several drops in one cycle add their total, with the same saturation
//  Output stage o: "free" = !out_valid[o] | out_ready[o].
//   - if free and >=1 request: grant one winner, pop its FIFO, and load out_data/out_src.
//     out_valid[o] is 1 after the edge.
//   - if free and no request: out_valid[o] goes to 0.
//   - if not free: data held stable, no grant; out_valid must not drop while out_ready is low.
//  Arbitration: per-output round-robin.
//   - search order starts at ptr[o]+1 mod NUM_PORTS; first requester wins
//   - ptr[o] updates to the winner only on an actual grant
//   - an input requests only one output, so no input is granted twice in a cycle
//  Latency: flit pushed at edge E into an empty FIFO with a free output gives out_valid high after edge E+1.
//  Throughput: 1 flit/cycle per output under continuous out_ready.
//  Simultaneous push and pop on one FIFO in the same cycle is legal; count is unchanged.
//  Loopback (dest == own input index) is legal and needs no special handling.
//  Ordering: flits from one input to one output leave in arrival order.
// TESTING
//  1 Single flit: in0 data=0xA5 dest=3, out_ready=1 -> out_valid[3] two edges later, out_data=0xA5, out_src=0; other ports silent.
//  2 Contention:
//    inputs 0,1,2 each send 4 flits to dest=4 -> grants in order 0,1,2,0,1,2...; 12 flits out with no gap cycles.
//  3 Backpressure:
//    out_ready[2]=0 while in1 sends 6 flits to dest 2 (FIFO_DEPTH=4) -> out holds 1, FIFO holds 4, in_ready[1]=0.
//    Release out_ready -> all 6 flits delivered in order.
//  4 Drop: in3 sends dest=6, then dest=7, then dest=1 -> drop_count=2; only the third flit appears, on out 1.
//    Force drop_count near max -> it stays at 2**CNT_W-1.
//  5 Parallel: in0->1, in1->2, in2->3, in3->4, in4->0 all at once -> all 5 outputs valid on the same cycle, out_src correct.
//  6 Reset mid-transfer: assert rst with 3 FIFOs non-empty and out_valid high -> out_valid=0 immediately (async).
//    After release: in_ready=all-1, no stale flits emerge.

Source files
------------

// File: rtl/noc_xbar_router.sv
// NUM_PORTS x NUM_PORTS NoC router: per-input FIFOs, per-output round-robin arbiters
// and registered output stages. Flits with an out-of-range dest are dropped and counted.
module noc_xbar_router #(
    parameter int unsigned NUM_PORTS  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEST_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS*DEST_W-1:0]      in_dest,
    input  logic [NUM_PORTS-1:0]             in_valid,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_PORTS*DEST_W-1:0]      out_src,
    output logic [NUM_PORTS-1:0]             out_valid,
    input  logic [NUM_PORTS-1:0]             out_ready,
    output logic [CNT_W-1:0]                 drop_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CNT_W + $clog2(NUM_PORTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] mem_data  [NUM_PORTS][FIFO_DEPTH];
    logic [DEST_W-1:0]     mem_dest  [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr    [NUM_PORTS];
    logic [AW-1:0]         rd_ptr    [NUM_PORTS];
    logic [CW-1:0]         count     [NUM_PORTS];
    logic [DATA_WIDTH-1:0] head_data [NUM_PORTS];
    logic [DEST_W-1:0]     head_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]  push, pop, drop, empty;

    logic [NUM_PORTS-1:0]  req       [NUM_PORTS];
    logic [NUM_PORTS-1:0]  grant     [NUM_PORTS];
    logic [DEST_W-1:0]     win       [NUM_PORTS];
    logic [DEST_W-1:0]     rr_ptr    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  free;

    logic [DATA_WIDTH-1:0] out_data_q [NUM_PORTS];
    logic [DEST_W-1:0]     out_src_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  out_valid_q;
    logic [CNT_W-1:0]      drop_cnt_q;
    logic [SW-1:0]         drop_sum;
    logic [CNT_W-1:0]      drop_next;

    // FIFO heads, handshake and per-output requests
    always_comb begin
        push = '0;
        drop = '0;
        empty = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            empty[i]     = (count[i] == '0);
            in_ready[i]  = (count[i] != CW'(FIFO_DEPTH));
            push[i]      = in_valid[i] & in_ready[i];
            head_data[i] = mem_data[i][rd_ptr[i]];
            head_dest[i] = mem_dest[i][rd_ptr[i]];
            drop[i]      = !empty[i] && (32'(head_dest[i]) >= NUM_PORTS);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                req[o][i] = !empty[i] && (32'(head_dest[i]) == 32'(o));
        end
    end

    // Round-robin arbitration starting after the last winner
    always_comb begin
        int idx;
        pop = drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            free[o]  = !out_valid_q[o] | out_ready[o];
            grant[o] = '0;
            win[o]   = '0;
            for (int k = 1; k <= int'(NUM_PORTS); k++) begin
                idx = (int'(rr_ptr[o]) + k) % int'(NUM_PORTS);
                if (free[o] && (grant[o] == '0) && req[o][idx]) begin
                    grant[o][idx] = 1'b1;
                    win[o]        = DEST_W'(idx);
                end
            end
            pop = pop | grant[o];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                mem_dest[i][wr_ptr[i]] <= in_dest[i*DEST_W +: DEST_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_data_q[o] <= '0;
                out_src_q[o]  <= '0;
                rr_ptr[o]     <= DEST_W'(NUM_PORTS - 1);
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (free[o]) begin
                    out_valid_q[o] <= |grant[o];
                    if (|grant[o]) begin
                        out_data_q[o] <= head_data[win[o]];
                        out_src_q[o]  <= win[o];
                        rr_ptr[o]     <= win[o];
                    end
                end
            end
        end
    end

    // Saturating drop counter; several drops per cycle add together
    always_comb begin
        drop_sum  = SW'(drop_cnt_q) + SW'($countones(drop));
        drop_next = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_next;
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_data[o*DATA_WIDTH +: DATA_WIDTH] = out_data_q[o];
            out_src[o*DEST_W +: DEST_W]          = out_src_q[o];
        end
    end

    assign out_valid  = out_valid_q;
    assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_noc_xbar_router.sv
// Directed bench for noc_xbar_router; a second instance with a 2-bit drop counter covers saturation.
module tb_noc_xbar_router;
    localparam int NP = 5;
    localparam int DW = 32;
    localparam int SWD = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*DW-1:0]  in_data;
    logic [NP*SWD-1:0] in_dest;
    logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready;
    logic [NP*DW-1:0]  out_data;
    logic [NP*SWD-1:0] out_src;
    logic [15:0]       drop_count;

    logic [NP*DW-1:0]  s_in_data, s_out_data;
    logic [NP*SWD-1:0] s_in_dest, s_out_src;
    logic [NP-1:0]     s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [1:0]        s_drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int port; logic [31:0] data; logic [2:0] src; int cyc; } rec_t;
    rec_t cap[$];

    noc_xbar_router dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    noc_xbar_router #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_dest(s_in_dest), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_src(s_out_src), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .drop_count(s_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer that completes at the coming edge
    always @(negedge clk) begin
        rec_t r;
        for (int o = 0; o < NP; o++) begin
            if (out_valid[o] && out_ready[o]) begin
                r.port = o;
                r.data = out_data[o*DW +: DW];
                r.src  = out_src[o*SWD +: SWD];
                r.cyc  = cyc;
                cap.push_back(r);
            end
        end
    end

    function automatic logic [31:0] od(int o);
        return out_data[o*DW +: DW];
    endfunction

    function automatic logic [2:0] os(int o);
        return out_src[o*SWD +: SWD];
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_one(int p, logic [31:0] d, logic [2:0] dst);
        bit done = 1'b0;
        in_data[p*DW +: DW]   = d;
        in_dest[p*SWD +: SWD] = dst;
        in_valid[p] = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            done = in_ready[p];
            tick(1);
        end
        in_valid[p] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout port %0d data %h: never accepted", p, d);
        end
    endtask

    task automatic test_reset();
        checks += 6;
        if (in_ready !== 5'h1f) begin errors++; $display("FAIL rst_in_ready got %b exp 11111", in_ready); end
        if (out_valid !== 5'h00) begin errors++; $display("FAIL rst_out_valid got %b exp 00000", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        if (out_src !== '0) begin errors++; $display("FAIL rst_out_src got %h exp 0", out_src); end
        if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
        if (s_drop !== 2'd0) begin errors++; $display("FAIL rst_sat_drop got %0d exp 0", s_drop); end
    endtask

    task automatic test_single();
        in_data[0 +: DW]  = 32'hA5;
        in_dest[0 +: SWD] = 3'd3;
        in_valid = 5'b00001;
        tick(1);
        in_valid = '0;
        checks += 5;
        if (out_valid !== 5'b00000) begin errors++; $display("FAIL single_early got %b exp 00000", out_valid); end
        tick(1);
        if (out_valid !== 5'b01000) begin errors++; $display("FAIL single_valid got %b exp 01000", out_valid); end
        if (od(3) !== 32'hA5) begin errors++; $display("FAIL single_data got %h exp a5", od(3)); end
        if (os(3) !== 3'd0) begin errors++; $display("FAIL single_src got %0d exp 0", os(3)); end
        tick(1);
        if (out_valid !== 5'b00000) begin errors++; $display("FAIL single_after got %b exp 00000", out_valid); end
    endtask

    task automatic test_contention();
        rec_t got[$];
        cap.delete();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                in_data[i*DW +: DW]   = 32'h400 + 32'(16 * i + k);
                in_dest[i*SWD +: SWD] = 3'd4;
            end
            in_valid = 5'b00111;
            tick(1);
        end
        in_valid = '0;
        tick(20);
        foreach (cap[n]) if (cap[n].port == 4) got.push_back(cap[n]);
        checks++;
        if (got.size() != 12) begin errors++; $display("FAIL cont_count got %0d exp 12", got.size()); end
        for (int n = 0; n < got.size() && n < 12; n++) begin
            checks += 3;
            if (got[n].src !== 3'(n % 3)) begin
                errors++; $display("FAIL cont_src[%0d] got %0d exp %0d", n, got[n].src, n % 3);
            end
            if (got[n].data !== 32'h400 + 32'(16 * (n % 3) + n / 3)) begin
                errors++; $display("FAIL cont_data[%0d] got %h exp %h", n, got[n].data, 32'h400 + 32'(16 * (n % 3) + n / 3));
            end
            if (got[n].cyc != got[0].cyc + n) begin
                errors++; $display("FAIL cont_gap[%0d] got cyc %0d exp %0d", n, got[n].cyc, got[0].cyc + n);
            end
        end
    endtask

    task automatic test_backpressure();
        rec_t got[$];
        bit done = 1'b0;
        cap.delete();
        out_ready = 5'b11011;
        for (int k = 0; k < 5; k++) push_one(1, 32'h200 + 32'(k), 3'd2);
        in_data[1*DW +: DW]   = 32'h205;
        in_dest[1*SWD +: SWD] = 3'd2;
        in_valid[1] = 1'b1;
        tick(3);
        checks += 3;
        if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready[1]); end
        if (out_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", out_valid[2]); end
        if (od(2) !== 32'h200) begin errors++; $display("FAIL bp_hold_data got %h exp 200", od(2)); end
        out_ready = 5'h1f;
        for (int t = 0; t < 50 && !done; t++) begin
            done = in_ready[1];
            tick(1);
        end
        in_valid[1] = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL bp_release_push got stuck exp accepted"); end
        tick(15);
        foreach (cap[n]) if (cap[n].port == 2) got.push_back(cap[n]);
        checks++;
        if (got.size() != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", got.size()); end
        for (int n = 0; n < got.size() && n < 6; n++) begin
            checks++;
            if (got[n].data !== 32'h200 + 32'(n) || got[n].src !== 3'd1) begin
                errors++; $display("FAIL bp_flit[%0d] got %h/%0d exp %h/1", n, got[n].data, got[n].src, 32'h200 + 32'(n));
            end
        end
    endtask

    task automatic test_drop();
        cap.delete();
        push_one(3, 32'h300, 3'd6);
        push_one(3, 32'h301, 3'd7);
        push_one(3, 32'h302, 3'd1);
        tick(6);
        checks += 2;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL drop_count got %0d exp 2", drop_count); end
        if (cap.size() != 1) begin errors++; $display("FAIL drop_outputs got %0d exp 1", cap.size()); end
        if (cap.size() >= 1) begin
            checks++;
            if (cap[0].port != 1 || cap[0].data !== 32'h302 || cap[0].src !== 3'd3) begin
                errors++; $display("FAIL drop_survivor got port %0d %h src %0d exp port 1 302 src 3", cap[0].port, cap[0].data, cap[0].src);
            end
        end
    endtask

    task automatic test_saturation();
        s_in_dest = {5{3'd7}};
        s_in_valid = 5'b00011;
        tick(1);
        s_in_valid = '0;
        tick(3);
        checks += 4;
        if (s_drop !== 2'd2) begin errors++; $display("FAIL sat_two got %0d exp 2", s_drop); end
        s_in_valid = 5'b11100;
        tick(1);
        s_in_valid = '0;
        tick(3);
        if (s_drop !== 2'd3) begin errors++; $display("FAIL sat_multi got %0d exp 3", s_drop); end
        s_in_valid = 5'b00001;
        tick(1);
        s_in_valid = '0;
        tick(3);
        if (s_drop !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", s_drop); end
        if (s_out_valid !== 5'b0) begin errors++; $display("FAIL sat_no_out got %b exp 00000", s_out_valid); end
    endtask

    task automatic test_parallel();
        for (int i = 0; i < NP; i++) begin
            in_data[i*DW +: DW]   = 32'h500 + 32'(i);
            in_dest[i*SWD +: SWD] = 3'((i + 1) % NP);
        end
        in_valid = 5'h1f;
        tick(1);
        in_valid = '0;
        tick(1);
        checks++;
        if (out_valid !== 5'h1f) begin errors++; $display("FAIL par_valid got %b exp 11111", out_valid); end
        for (int o = 0; o < NP; o++) begin
            checks += 2;
            if (os(o) !== 3'((o + 4) % NP)) begin
                errors++; $display("FAIL par_src[%0d] got %0d exp %0d", o, os(o), (o + 4) % NP);
            end
            if (od(o) !== 32'h500 + 32'((o + 4) % NP)) begin
                errors++; $display("FAIL par_data[%0d] got %h exp %h", o, od(o), 32'h500 + 32'((o + 4) % NP));
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                in_data[i*DW +: DW]   = 32'h600 + 32'(16 * i + k);
                in_dest[i*SWD +: SWD] = 3'd0;
            end
            in_valid = 5'b00111;
            tick(1);
        end
        in_valid = '0;
        tick(2);
        checks += 7;
        if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid[0]); end
        #3 rst = 1'b1;
        #1;
        if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 00000", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL mid_async_data got %h exp 0", out_data); end
        if (drop_count !== 16'd0) begin errors++; $display("FAIL mid_async_drop got %0d exp 0", drop_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 5'h1f;
        cap.delete();
        if (in_ready !== 5'h1f) begin errors++; $display("FAIL mid_in_ready got %b exp 11111", in_ready); end
        tick(10);
        if (cap.size() != 0) begin errors++; $display("FAIL mid_stale got %0d flits exp 0", cap.size()); end
        if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_idle_valid got %b exp 00000", out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0; in_dest = '0; in_valid = '0; out_ready = 5'h1f;
        s_in_data = '0; s_in_dest = '0; s_in_valid = '0; s_out_ready = 5'h1f;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick(1);
        test_reset();
        test_single();
        tick(2);
        test_contention();
        test_backpressure();
        test_drop();
        test_saturation();
        tick(2);
        test_parallel();
        tick(3);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
